// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM slave input port with per-bit edge capture and a level IRQ.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset; clears every flop
//   address     word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect  slave select; readdata is 0 when low
//   write_n     active-low write strobe
//   writedata   write data; only [WIDTH-1:0] is used
//   readdata    combinational read data, zero wait states
//   in_port     asynchronous external inputs (keys, switches)
//   irq         registered level interrupt: any captured edge whose mask bit is set
module pio_in_edge_irq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0   // 0 rising, 1 falling, 2 any
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    // Once the chain and prev hold post-reset samples, edges become trustworthy.
    localparam logic [CNT_W-1:0] ARM_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             armed;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign wr_en = chipselect & ~write_n;
    assign armed = (arm_cnt_q == ARM_DONE);
    assign rise  = sync & ~prev_q;
    assign fall  = ~sync & prev_q;

    always_comb begin
        det = '0;
        if (armed) begin
            case (EDGE_TYPE)
                0:       det = rise;
                1:       det = fall;
                default: det = rise | fall;
            endcase
        end
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d    = sync;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
        // A fresh edge outranks a simultaneous clear.
        edgecap_d = det | (edgecap_q & ~clr);
        irqmask_d = irqmask_q;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
            arm_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            edgecap_q <= edgecap_d;
            irqmask_q <= irqmask_d;
            arm_cnt_q <= arm_cnt_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata[WIDTH-1:0] = sync;
                2'd2:    readdata[WIDTH-1:0] = irqmask_q;
                2'd3:    readdata[WIDTH-1:0] = edgecap_q;
                default: readdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic unused_writedata;
            assign unused_writedata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
